// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } sweep_state_e;

  localparam int unsigned NInDefault = 4;

  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Load/decrement settle counter; zero_o flags that the current vector has settled.
module tt_settle_timer #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  // Keep at least one bit so SETTLE_CYC == 0 still yields a legal register.
  localparam int unsigned CntW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE_CYC);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input vector of a truth-table gate, records the response table
// and compares it against a reference latched at start.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = NInDefault,
  parameter int unsigned SETTLE_CYC = 2,
  localparam int unsigned TT_W      = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            result_valid,
  output logic [TT_W-1:0] tt,
  output logic            match,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err
);

  localparam int unsigned ErrW = N_IN + 1;
  localparam logic [N_IN-1:0] IdxLast = N_IN'(TT_W - 1);

  sweep_state_e    state_q;
  logic [N_IN-1:0] idx_q;
  logic            busy_q;
  logic            done_q;
  logic            rv_q;
  logic [TT_W-1:0] tt_q;
  logic [TT_W-1:0] exp_q;
  logic [N_IN:0]   err_cnt_q;
  logic [N_IN-1:0] first_err_q;

  logic            timer_load;
  logic            timer_dec;
  logic            timer_zero;
  logic [N_IN-1:0] bit_pos;
  logic            mismatch;

  // Index i lives at bit TT_W-1-i, which for TT_W = 2**N_IN is just ~i.
  assign bit_pos  = ~idx_q;
  assign mismatch = (gate_out != exp_q[bit_pos]);

  always_comb begin
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      StIdle:  timer_load = start;
      StDrive: begin
        if (!abort) begin
          if (!timer_zero) begin
            timer_dec = 1'b1;
          end else if (idx_q != IdxLast) begin
            timer_load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  tt_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .zero_o (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rv_q        <= 1'b0;
      tt_q        <= '0;
      exp_q       <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= StDrive;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            rv_q        <= 1'b0;
            tt_q        <= '0;
            exp_q       <= expected;
            err_cnt_q   <= '0;
            first_err_q <= '0;
          end
        end
        StDrive: begin
          if (abort) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (timer_zero) begin
            tt_q[bit_pos] <= gate_out;
            if (mismatch) begin
              err_cnt_q <= err_cnt_q + ErrW'(1);
              if (err_cnt_q == '0) begin
                first_err_q <= idx_q;
              end
            end
            if (idx_q == IdxLast) begin
              state_q <= StDone;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              rv_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + N_IN'(1);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gate_in      = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = rv_q;
  assign tt           = tt_q;
  assign match        = rv_q && (tt_q == exp_q);
  assign err_cnt      = err_cnt_q;
  assign first_err    = first_err_q;

endmodule
